// File: rtl/prewish_button_loader.sv
// Debounced pushbutton + DIP switch loader: one STB_O and a captured switch byte per accepted press.
// Latency 2**DEBOUNCE_BITS + 3 clocks from pin to STB_O; no backpressure, a strobe is never held.
module prewish_button_loader #(
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       i_button_n,
  input  logic [7:0] i_switches,
  output logic       STB_O,
  output logic [7:0] DAT_O,
  output logic       o_pressed
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX = '1;

  logic                     btn_s1;
  logic                     btn_s2;
  logic [7:0]               sw_s1;
  logic [7:0]               sw_s2;
  logic                     pressed;
  state_t                   state;
  logic [DEBOUNCE_BITS-1:0] cnt;

  assign pressed = ~btn_s2;

  // The counter only runs in the two wait states; the terminal compare always leaves them, so it never wraps.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      btn_s1    <= 1'b1;
      btn_s2    <= 1'b1;
      sw_s1     <= '0;
      sw_s2     <= '0;
      state     <= IDLE;
      cnt       <= '0;
      STB_O     <= 1'b0;
      DAT_O     <= '0;
      o_pressed <= 1'b0;
    end else begin
      btn_s1 <= i_button_n;
      btn_s2 <= btn_s1;
      sw_s1  <= i_switches;
      sw_s2  <= sw_s1;
      STB_O  <= 1'b0;
      case (state)
        IDLE: begin
          if (pressed) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!pressed) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state     <= HELD;
            cnt       <= '0;
            STB_O     <= 1'b1;
            DAT_O     <= sw_s2;
            o_pressed <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!pressed) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (pressed) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state     <= IDLE;
            cnt       <= '0;
            o_pressed <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          o_pressed <= 1'b0;
        end
      endcase
    end
  end

endmodule
